// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller. Produces the PC write enable and the
//   stall/flush controls of the IF/ID and ID/EX pipeline registers.
//   It handles three hazards:
//     - load-use: a one-cycle bubble while the load in EX completes;
//     - taken branch/jump resolved in ID: the fetched IF instruction is flushed;
//     - mult/div occupancy: any HI/LO consumer or new mult/div in ID stalls
//       until the unit has finished.
//   It also keeps a saturating count of stalled cycles.
//
// Parameters
//   MD_LATENCY  cycles from a mult/div op in EX until HI/LO is valid (2..255)
//   CNT_W       width of the stall-cycle counter
//
// Ports
//   clk, rst                    clock; synchronous active-high reset
//   ID_rs, ID_rt, ID_uses_rt    source operands of the instruction in ID
//   ID_branch_taken             branch/jump in ID resolved taken
//   ID_is_md, ID_reads_hilo     ID instruction is mult/div, or mfhi/mflo
//   EX_MemRead, EX_rt           load in EX and its destination register
//   EX_is_md                    mult/div op in EX
//   PCWrite, IFWrite            PC / IF-ID write enables
//   IFflush, IDEX_flush         IF-ID nop insert / ID-EX bubble insert
//   md_busy                     mult/div unit occupied
//   stall_cycles                saturating count of stalled cycles
module hazard_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rt,
    input  logic             ID_branch_taken,
    input  logic             ID_is_md,
    input  logic             ID_reads_hilo,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rt,
    input  logic             EX_is_md,
    output logic             PCWrite,
    output logic             IFWrite,
    output logic             IFflush,
    output logic             IDEX_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MDC_W = 8;
    localparam logic [MDC_W-1:0] MD_RELOAD = MDC_W'(MD_LATENCY - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic pc_we;
        logic if_we;
        logic if_flush;
        logic idex_flush;
    } ctl_t;

    state_t           state;
    logic [MDC_W-1:0] md_cnt;

    logic md_busy_raw;
    logic load_use;
    logic md_haz;
    logic stall;
    ctl_t ctl;

    // ------------------------------------------------------------------
    // Mult/div occupancy tracker. md_cnt counts the busy cycles still to
    // come after the current one; the op's own EX cycle is covered by
    // EX_is_md directly, so the load value is MD_LATENCY-1.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (EX_is_md) begin
                        state  <= MD_BUSY;
                        md_cnt <= MD_RELOAD;
                    end
                end
                MD_BUSY: begin
                    // A second op reaching EX while busy restarts the wait.
                    if (EX_is_md) begin
                        md_cnt <= MD_RELOAD;
                    end else if (md_cnt == MDC_W'(1)) begin
                        state  <= RUN;
                        md_cnt <= '0;
                    end else begin
                        md_cnt <= md_cnt - MDC_W'(1);
                    end
                end
                default: begin
                    state  <= RUN;
                    md_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign md_busy_raw = (state == MD_BUSY) | EX_is_md;

    // $0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = EX_MemRead & (EX_rt != 5'd0) &
                      ((EX_rt == ID_rs) | (ID_uses_rt & (EX_rt == ID_rt)));

    assign md_haz = md_busy_raw & (ID_reads_hilo | ID_is_md);
    assign stall  = load_use | md_haz;

    // ------------------------------------------------------------------
    // Output priority: reset, stall, taken branch, normal flow.
    // A stall overrides a taken branch because the branch operands may be
    // stale; the branch resolves again once the stall clears.
    // ------------------------------------------------------------------
    always_comb begin
        ctl = '{pc_we: 1'b1, if_we: 1'b1, if_flush: 1'b0, idex_flush: 1'b0};
        if (rst) begin
            ctl = '{pc_we: 1'b0, if_we: 1'b0, if_flush: 1'b1, idex_flush: 1'b1};
        end else if (stall) begin
            ctl = '{pc_we: 1'b0, if_we: 1'b0, if_flush: 1'b0, idex_flush: 1'b1};
        end else if (ID_branch_taken) begin
            ctl = '{pc_we: 1'b1, if_we: 1'b1, if_flush: 1'b1, idex_flush: 1'b0};
        end
    end

    assign PCWrite    = ctl.pc_we;
    assign IFWrite    = ctl.if_we;
    assign IFflush    = ctl.if_flush;
    assign IDEX_flush = ctl.idex_flush;
    assign md_busy    = ~rst & md_busy_raw;

    // ------------------------------------------------------------------
    // Stall-cycle counter, saturating at all-ones.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int MDL   = 4;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       ID_rs, ID_rt, EX_rt;
    logic             ID_uses_rt, ID_branch_taken, ID_is_md, ID_reads_hilo;
    logic             EX_MemRead, EX_is_md;
    logic             PCWrite, IFWrite, IFflush, IDEX_flush, md_busy;
    logic [CNT_W-1:0] stall_cycles;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: number of busy cycles remaining after the current one,
    // and the stall count as a plain integer.
    int m_rem = 0;
    int m_cnt = 0;

    hazard_ctrl #(.MD_LATENCY(MDL), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
        .ID_branch_taken(ID_branch_taken), .ID_is_md(ID_is_md),
        .ID_reads_hilo(ID_reads_hilo), .EX_MemRead(EX_MemRead),
        .EX_rt(EX_rt), .EX_is_md(EX_is_md),
        .PCWrite(PCWrite), .IFWrite(IFWrite), .IFflush(IFflush),
        .IDEX_flush(IDEX_flush), .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_busy();
        return EX_is_md || (m_rem > 0);
    endfunction

    function automatic logic m_stall();
        logic lu;
        lu = EX_MemRead && (EX_rt != 0) &&
             ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
        return lu || (m_busy() && (ID_reads_hilo || ID_is_md));
    endfunction

    // {PCWrite, IFWrite, IFflush, IDEX_flush, md_busy}
    function automatic logic [4:0] m_ctl();
        if (rst)                  return 5'b00110;
        if (m_stall())            return {4'b0001, m_busy()};
        if (ID_branch_taken)      return {4'b1110, m_busy()};
        return {4'b1100, m_busy()};
    endfunction

    task automatic cycle();
        @(negedge clk);
        chk("ctl", {27'd0, PCWrite, IFWrite, IFflush, IDEX_flush, md_busy}, {27'd0, m_ctl()});
        chk("cnt", 32'(stall_cycles), 32'(m_cnt));
        @(posedge clk);
        if (rst) begin
            m_rem = 0;
            m_cnt = 0;
        end else begin
            if (m_stall()) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            if (EX_is_md)       m_rem = MDL - 1;
            else if (m_rem > 0) m_rem = m_rem - 1;
        end
        #1;
    endtask

    task automatic idle();
        ID_rs = 0; ID_rt = 0; EX_rt = 0; ID_uses_rt = 0; ID_branch_taken = 0;
        ID_is_md = 0; ID_reads_hilo = 0; EX_MemRead = 0; EX_is_md = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 0;
        cycle();
        chk("rst_cnt", 32'(stall_cycles), 0);

        // load-use on rs, then $0 destination
        EX_MemRead = 1; EX_rt = 8; ID_rs = 8;
        cycle();
        idle();
        cycle();
        chk("lu_rs_cnt", 32'(stall_cycles), 1);
        EX_MemRead = 1; EX_rt = 0; ID_rs = 0;
        cycle();
        idle();
        chk("lu_r0_cnt", 32'(stall_cycles), 1);

        // load-use on rt only when rt is a source
        EX_MemRead = 1; EX_rt = 9; ID_rt = 9; ID_rs = 1; ID_uses_rt = 0;
        cycle();
        ID_uses_rt = 1;
        cycle();
        idle();
        chk("lu_rt_cnt", 32'(stall_cycles), 2);

        // branch alone, branch under stall, branch after the stall clears
        ID_branch_taken = 1;
        cycle();
        EX_MemRead = 1; EX_rt = 5; ID_rs = 5;
        cycle();
        EX_MemRead = 0;
        @(negedge clk);
        chk("br_after_stall", {31'd0, IFflush}, 1);
        cycle();
        idle();

        // mult/div wait with a HI/LO reader held in ID
        do_reset();
        EX_is_md = 1; ID_reads_hilo = 1;
        cycle();
        EX_is_md = 0;
        repeat (MDL) cycle();
        chk("md_cnt", 32'(stall_cycles), MDL);
        idle();

        // reset two cycles into MD_BUSY
        EX_is_md = 1;
        cycle();
        EX_is_md = 0;
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0; ID_reads_hilo = 1;
        #1;
        chk("md_rst_busy", {31'd0, md_busy}, 0);
        cycle();
        idle();

        // counter saturation
        do_reset();
        EX_MemRead = 1; EX_rt = 8; ID_rs = 8;
        repeat (10) cycle();
        chk("sat_cnt", 32'(stall_cycles), CMAX);
        idle();

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rst             = ($urandom_range(0, 39) == 0);
            ID_rs           = 5'($urandom_range(0, 3));
            ID_rt           = 5'($urandom_range(0, 3));
            EX_rt           = 5'($urandom_range(0, 3));
            ID_uses_rt      = 1'($urandom_range(0, 1));
            ID_branch_taken = 1'($urandom_range(0, 1));
            ID_is_md        = ($urandom_range(0, 7) == 0);
            ID_reads_hilo   = ($urandom_range(0, 3) == 0);
            EX_MemRead      = ($urandom_range(0, 2) == 0);
            EX_is_md        = ($urandom_range(0, 11) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller that drives the stall and flush inputs of the IF/ID and ID/EX pipeline registers and the PC write enable.
- Detects three conditions:
  - load-use data hazards, resolved with a one-cycle bubble;
  - taken branches and jumps resolved in ID, resolved by flushing IF;
  - multi-cycle multiply/divide occupancy, resolved by stalling any HI/LO consumer until the result is ready.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- MD_LATENCY, 32: cycles from a mult/div op being in EX until HI/LO is valid. Legal range 2..255.
- CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- ID_rs  in  5  rs field of the instruction in ID
- ID_rt  in  5  rt field of the instruction in ID
- ID_uses_rt  in  1  ID instruction reads rt as a source
- ID_branch_taken  in  1  branch/jump in ID resolved taken this cycle
- ID_is_md  in  1  ID instruction is mult/multu/div/divu
- ID_reads_hilo  in  1  ID instruction is mfhi/mflo
- EX_MemRead  in  1  instruction in EX is a load
- EX_rt  in  5  destination register of the load in EX
- EX_is_md  in  1  instruction in EX is a mult/div op
- PCWrite  out  1  PC update enable
- IFWrite  out  1  IF/ID write enable
- IFflush  out  1  IF/ID flush (inserts nop)
- IDEX_flush  out  1  ID/EX flush (inserts bubble)
- md_busy  out  1  mult/div unit occupied
- stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset:
  - rst is synchronous, active-high.
  - On a posedge with rst=1: state<=RUN, md_cnt<=0, stall_cycles<=0.
  - While rst=1, outputs are forced: PCWrite=0, IFWrite=0, IFflush=1, IDEX_flush=1, md_busy=0.
  - Reset mid-MD_BUSY abandons the count immediately.
- FSM states:
  - RUN: no mult/div outstanding.
  - MD_BUSY: mult/div in progress; md_cnt holds remaining cycles.
- FSM transitions:
  - RUN -> MD_BUSY when EX_is_md=1; md_cnt<=MD_LATENCY-1.
  - MD_BUSY, md_cnt!=1: md_cnt decrements each cycle.
  - MD_BUSY, md_cnt==1: next state RUN, md_cnt<=0.
  - MD_BUSY with EX_is_md=1: md_cnt reloads to MD_LATENCY-1. This cannot occur normally because of the stall, but must be handled.
- md_busy = (state==MD_BUSY) | EX_is_md.
- Hazard terms (combinational):
  - load_use = EX_MemRead & (EX_rt!=0) & ((EX_rt==ID_rs) | (ID_uses_rt & EX_rt==ID_rt))
  - md_haz = md_busy & (ID_reads_hilo | ID_is_md)
  - stall = load_use | md_haz
- Output priority (outputs combinational, no latency):
  1. rst: forced values as above.
  2. stall: PCWrite=0, IFWrite=0, IFflush=0, IDEX_flush=1. A stall suppresses ID_branch_taken, because the branch operands may be stale; the branch re-resolves next cycle.
  3. ID_branch_taken: PCWrite=1, IFWrite=1, IFflush=1, IDEX_flush=0.
  4. Otherwise: PCWrite=1, IFWrite=1, IFflush=0, IDEX_flush=0.
- Load-use produces exactly one bubble: after the bubble, EX_MemRead deasserts.
- md_haz holds for every cycle that md_busy=1. The first non-stalled cycle is the cycle after state returns to RUN, i.e. MD_LATENCY cycles after EX_is_md first seen.
- stall_cycles increments on each posedge where stall=1 and rst=0. It saturates at all-ones and does not wrap.
- Register $0 never causes a load-use hazard.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0, all inputs 0 -> during reset PCWrite=0, IFflush=1, IDEX_flush=1; after release PCWrite=1, IFWrite=1, IFflush=0, stall_cycles=0.
- Load-use on rs:
  - EX_MemRead=1, EX_rt=8, ID_rs=8 for 1 cycle, then EX_MemRead=0 -> one cycle with PCWrite=0, IFWrite=0, IDEX_flush=1; stall_cycles=1.
  - Repeat with EX_rt=0 -> no stall.
- Load-use on rt gating: EX_rt=9, ID_rt=9, ID_uses_rt=0 -> no stall; same with ID_uses_rt=1 -> one-cycle stall.
- Branch flush vs stall:
  - ID_branch_taken=1 alone -> IFflush=1, PCWrite=1, IDEX_flush=0.
  - ID_branch_taken=1 together with load_use -> IFflush=0, IDEX_flush=1; the next cycle, with the hazard gone, -> IFflush=1.
- Mult/div wait, MD_LATENCY=4: EX_is_md=1 for one cycle, ID_reads_hilo held at 1 -> md_busy high for 4 cycles, stall for 4 cycles, release on the 5th; stall_cycles=4.
- Reset mid-MD_BUSY plus saturation:
  - rst asserted 2 cycles into MD_BUSY -> state RUN, md_busy=0 once rst drops.
  - With CNT_W=3 and a stall held for 10 cycles -> stall_cycles=7, no wrap.
